// File: rtl/mem_resp_pkg.sv
// -----------------------------------------------------------------------------
// mem_resp_pkg
// Shared definitions for the memory response unit: access-size encodings,
// FSM state enumeration, wait counter width and the alignment check.
// -----------------------------------------------------------------------------
package mem_resp_pkg;

   typedef enum logic [1:0] {
      SZ_WORD = 2'b00,
      SZ_BYTE = 2'b01,
      SZ_HALF = 2'b10,
      SZ_RSVD = 2'b11
   } size_e;

   typedef enum logic [2:0] {
      IDLE,
      WAIT,
      ACCESS,
      RESP,
      ERR
   } state_e;

   localparam int CNT_W = 4;

   // A byte access can never be misaligned; the reserved size always is.
   function automatic logic is_misaligned(input size_e sz, input logic [1:0] a);
      logic bad;
      bad = 1'b0;
      case (sz)
         SZ_WORD: bad = (a != 2'b00);
         SZ_HALF: bad = a[0];
         SZ_BYTE: bad = 1'b0;
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/mem_resp_ram.sv
// -----------------------------------------------------------------------------
// mem_resp_ram
// Single-port synchronous RAM, 32-bit words, per-byte write enables and a
// registered read port. Contents are never reset.
//   clk      in   clock
//   en_i     in   access enable (read and/or write this edge)
//   we_i     in   byte write enables, bit k writes bits 8k+7:8k
//   addr_i   in   word index
//   wdata_i  in   write data (already lane-positioned)
//   rdata_o  out  registered read data of the word at addr_i
// -----------------------------------------------------------------------------
module mem_resp_ram #(
   parameter int DEPTH_WORDS = 256,
   parameter int AW          = $clog2(DEPTH_WORDS)
) (
   input  logic          clk,
   input  logic          en_i,
   input  logic [3:0]    we_i,
   input  logic [AW-1:0] addr_i,
   input  logic [31:0]   wdata_i,
   output logic [31:0]   rdata_o
);

   logic [31:0] mem_q [DEPTH_WORDS];
   logic [31:0] rdata_q;

   always_ff @(posedge clk) begin
      if (en_i) begin
         for (int k = 0; k < 4; k++) begin
            if (we_i[k]) begin
               mem_q[addr_i][8*k +: 8] <= wdata_i[8*k +: 8];
            end
         end
         rdata_q <= mem_q[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_resp_unit.sv
// -----------------------------------------------------------------------------
// mem_resp_unit
// CPU-facing memory responder: accepts one load/store at a time, adds
// WAIT_CYCLES wait states, accesses an internal byte-writable RAM and returns
// a one-cycle ack (with err for misaligned/reserved accesses).
//   clk    in   clock, rising edge
//   reset  in   asynchronous active-high reset
//   req    in   request valid, sampled only in IDLE
//   wr     in   1 = store, 0 = load
//   size   in   00 word, 01 byte, 10 halfword, 11 reserved
//   addr   in   byte address (aliases modulo DEPTH_WORDS*4)
//   wdata  in   store data, right-aligned
//   rdata  out  load result, sign-extended; held across stores and errors
//   ack    out  one-cycle completion pulse
//   err    out  one-cycle error pulse, coincident with ack
//   busy   out  high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module mem_resp_unit
   import mem_resp_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        wr,
   input  logic [1:0]  size,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ack,
   output logic        err,
   output logic        busy
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam logic [CNT_W-1:0] WAIT_LAST =
      (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              ack_q, ack_d;
   logic              err_q, err_d;

   logic              wr_q;
   size_e             size_q;
   logic [AW+1:0]     addr_q;
   logic [31:0]       wdata_q;

   logic              ram_en;
   logic [3:0]        ram_we;
   logic [3:0]        lane_be;
   logic [31:0]       lane_wdata;
   logic [31:0]       ram_rdata;
   logic [7:0]        byte_v;
   logic [15:0]       half_v;
   logic [31:0]       load_val;

   // Address bits above the array size simply alias.
   logic              unused_addr_hi;
   assign unused_addr_hi = ^addr[31:AW+2];

   // Request capture: data-only registers, loaded at the accepting edge.
   always_ff @(posedge clk) begin
      if (state_q == IDLE && req) begin
         wr_q    <= wr;
         size_q  <= size_e'(size);
         addr_q  <= addr[AW+1:0];
         wdata_q <= wdata;
      end
   end

   // Store lane steering: replicate the right-aligned data into every lane
   // and let the byte enables pick the addressed ones.
   always_comb begin
      lane_be    = 4'b0000;
      lane_wdata = wdata_q;
      case (size_q)
         SZ_BYTE: begin
            lane_be    = 4'b0001 << addr_q[1:0];
            lane_wdata = {4{wdata_q[7:0]}};
         end
         SZ_HALF: begin
            lane_be    = addr_q[1] ? 4'b1100 : 4'b0011;
            lane_wdata = {2{wdata_q[15:0]}};
         end
         SZ_WORD: lane_be = 4'b1111;
         default: lane_be = 4'b0000;
      endcase
   end

   // Gating with reset keeps a reset that coincides with ACCESS from
   // writing at that same edge.
   assign ram_en = (state_q == ACCESS) && !reset;
   assign ram_we = (ram_en && wr_q) ? lane_be : 4'b0000;

   mem_resp_ram #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .AW          (AW)
   ) u_ram (
      .clk     (clk),
      .en_i    (ram_en),
      .we_i    (ram_we),
      .addr_i  (addr_q[AW+1:2]),
      .wdata_i (lane_wdata),
      .rdata_o (ram_rdata)
   );

   // Load extraction and sign extension from the registered RAM word.
   always_comb begin
      byte_v = ram_rdata[{addr_q[1:0], 3'b000} +: 8];
      half_v = addr_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
      case (size_q)
         SZ_BYTE: load_val = {{24{byte_v[7]}}, byte_v};
         SZ_HALF: load_val = {{16{half_v[15]}}, half_v};
         default: load_val = ram_rdata;
      endcase
   end

   // Next-state logic. ack/err are registered on leaving RESP/ERR, so the
   // pulse lands in the first IDLE cycle.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      ack_d   = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (req) begin
               cnt_d = '0;
               if (is_misaligned(size_e'(size), addr[1:0])) begin
                  state_d = ERR;
               end else if (WAIT_CYCLES > 0) begin
                  state_d = WAIT;
               end else begin
                  state_d = ACCESS;
               end
            end
         end
         WAIT: begin
            if (cnt_q == WAIT_LAST) begin
               cnt_d   = '0;
               state_d = ACCESS;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ACCESS: state_d = RESP;
         RESP: begin
            ack_d   = 1'b1;
            state_d = IDLE;
            if (!wr_q) begin
               rdata_d = load_val;
            end
         end
         ERR: begin
            ack_d   = 1'b1;
            err_d   = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rdata_q <= '0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
      end
   end

   assign rdata = rdata_q;
   assign ack   = ack_q;
   assign err   = err_q;
   assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_mem_resp_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_resp_unit
// Directed, table-driven bench for mem_resp_unit. One instance runs with one
// wait state, a second with none for the back-to-back timing sequences.
// -----------------------------------------------------------------------------
module tb_mem_resp_unit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;

   logic        req, wr;
   logic [1:0]  size;
   logic [31:0] addr, wdata, rdata;
   logic        ack, err, busy;

   logic        req0, wr0;
   logic [1:0]  size0;
   logic [31:0] addr0, wdata0, rdata0;
   logic        ack0, err0, busy0;

   mem_resp_unit #(.DEPTH_WORDS(256), .WAIT_CYCLES(1)) dut (
      .clk(clk), .reset(reset), .req(req), .wr(wr), .size(size),
      .addr(addr), .wdata(wdata), .rdata(rdata), .ack(ack), .err(err),
      .busy(busy)
   );

   mem_resp_unit #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .reset(reset), .req(req0), .wr(wr0), .size(size0),
      .addr(addr0), .wdata(wdata0), .rdata(rdata0), .ack(ack0), .err(err0),
      .busy(busy0)
   );

   typedef struct {
      logic        wr;
      logic [1:0]  sz;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] rd;
      logic        er;
   } vec_t;

   localparam int NV = 28;
   vec_t tv [NV];

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // One complete transaction on the WAIT_CYCLES=1 instance.
   task automatic run_txn(input string tag, input logic w, input logic [1:0] s,
                          input logic [31:0] a, input logic [31:0] d,
                          input int exp_lat, input logic exp_err,
                          input logic [31:0] exp_rd);
      int          lat;
      logic [31:0] rd;
      logic        e;
      @(negedge clk);
      req = 1'b1; wr = w; size = s; addr = a; wdata = d;
      @(posedge clk); #1;
      req = 1'b0;
      check($sformatf("%s.busy_acc", tag), 32'(busy), 32'd1);
      lat = -1; rd = 'x; e = 1'bx;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         if (ack) begin
            lat = k; rd = rdata; e = err;
            break;
         end
      end
      check($sformatf("%s.latency", tag), 32'(lat), 32'(exp_lat));
      check($sformatf("%s.err", tag), 32'(e), 32'(exp_err));
      check($sformatf("%s.rdata", tag), rd, exp_rd);
      @(posedge clk); #1;
      check($sformatf("%s.ack_drop", tag), {busy, ack}, 32'd0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      tv[0]  = '{1'b1, 2'b00, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
      tv[1]  = '{1'b0, 2'b00, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
      tv[2]  = '{1'b1, 2'b01, 32'h0000_0012, 32'h0000_0080, 32'hDEAD_BEEF, 1'b0};
      tv[3]  = '{1'b0, 2'b01, 32'h0000_0012, 32'h0,         32'hFFFF_FF80, 1'b0};
      tv[4]  = '{1'b0, 2'b00, 32'h0000_0010, 32'h0,         32'hDE80_BEEF, 1'b0};
      tv[5]  = '{1'b0, 2'b10, 32'h0000_0013, 32'h0,         32'hDE80_BEEF, 1'b1};
      tv[6]  = '{1'b0, 2'b00, 32'h0000_0010, 32'h0,         32'hDE80_BEEF, 1'b0};
      tv[7]  = '{1'b0, 2'b10, 32'h0000_0012, 32'h0,         32'hFFFF_DE80, 1'b0};
      tv[8]  = '{1'b0, 2'b10, 32'h0000_0010, 32'h0,         32'hFFFF_BEEF, 1'b0};
      tv[9]  = '{1'b0, 2'b01, 32'h0000_0011, 32'h0,         32'hFFFF_FFBE, 1'b0};
      tv[10] = '{1'b1, 2'b00, 32'h0000_0014, 32'h5566_7788, 32'hFFFF_FFBE, 1'b0};
      tv[11] = '{1'b1, 2'b10, 32'h0000_0016, 32'hABCD_1234, 32'hFFFF_FFBE, 1'b0};
      tv[12] = '{1'b0, 2'b00, 32'h0000_0014, 32'h0,         32'h1234_7788, 1'b0};
      tv[13] = '{1'b0, 2'b10, 32'h0000_0014, 32'h0,         32'h0000_7788, 1'b0};
      tv[14] = '{1'b0, 2'b01, 32'h0000_0017, 32'h0,         32'h0000_0012, 1'b0};
      tv[15] = '{1'b1, 2'b01, 32'h0000_0015, 32'h0000_00F0, 32'h0000_0012, 1'b0};
      tv[16] = '{1'b0, 2'b00, 32'h0000_0014, 32'h0,         32'h1234_F088, 1'b0};
      tv[17] = '{1'b1, 2'b00, 32'h0000_0400, 32'h1111_1111, 32'h1234_F088, 1'b0};
      tv[18] = '{1'b0, 2'b00, 32'h0000_0000, 32'h0,         32'h1111_1111, 1'b0};
      tv[19] = '{1'b1, 2'b00, 32'h0000_0002, 32'hFFFF_FFFF, 32'h1111_1111, 1'b1};
      tv[20] = '{1'b1, 2'b11, 32'h0000_0000, 32'hFFFF_FFFF, 32'h1111_1111, 1'b1};
      tv[21] = '{1'b1, 2'b10, 32'h0000_0401, 32'hFFFF_FFFF, 32'h1111_1111, 1'b1};
      tv[22] = '{1'b0, 2'b00, 32'h0000_0000, 32'h0,         32'h1111_1111, 1'b0};
      tv[23] = '{1'b0, 2'b00, 32'hFFFF_FC14, 32'h0,         32'h1234_F088, 1'b0};
      tv[24] = '{1'b0, 2'b01, 32'h0000_0014, 32'h0,         32'hFFFF_FF88, 1'b0};
      tv[25] = '{1'b1, 2'b01, 32'h0000_0010, 32'h0000_007F, 32'hFFFF_FF88, 1'b0};
      tv[26] = '{1'b0, 2'b01, 32'h0000_0010, 32'h0,         32'h0000_007F, 1'b0};
      tv[27] = '{1'b0, 2'b00, 32'h0000_0010, 32'h0,         32'hDE80_BE7F, 1'b0};

      reset = 1'b1;
      req = 1'b0; wr = 1'b0; size = 2'b00; addr = '0; wdata = '0;
      req0 = 1'b0; wr0 = 1'b0; size0 = 2'b00; addr0 = '0; wdata0 = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst.busy",  32'(busy),  32'd0);
      check("rst.ack",   32'(ack),   32'd0);
      check("rst.err",   32'(err),   32'd0);
      check("rst.rdata", rdata,      32'd0);
      check("rst.busy0", 32'(busy0), 32'd0);
      check("rst.rdata0", rdata0,    32'd0);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < NV; i++) begin
         run_txn($sformatf("v%0d", i), tv[i].wr, tv[i].sz, tv[i].addr, tv[i].wd,
                 tv[i].er ? 1 : 3, tv[i].er, tv[i].rd);
      end

      // Reset during WAIT of a store: aborted, old contents survive.
      run_txn("pre20", 1'b1, 2'b00, 32'h20, 32'hCAFE_F00D, 3, 1'b0, 32'hDE80_BE7F);
      @(negedge clk);
      req = 1'b1; wr = 1'b1; size = 2'b00; addr = 32'h20; wdata = 32'h1234_5678;
      @(posedge clk); #1;
      req = 1'b0;
      check("rwait.busy_before", 32'(busy), 32'd1);
      #2 reset = 1'b1;
      #1;
      check("rwait.busy",  32'(busy), 32'd0);
      check("rwait.ack",   32'(ack),  32'd0);
      check("rwait.err",   32'(err),  32'd0);
      check("rwait.rdata", rdata,     32'd0);
      @(negedge clk);
      reset = 1'b0;
      run_txn("rwait.load", 1'b0, 2'b00, 32'h20, 32'h0, 3, 1'b0, 32'hCAFE_F00D);

      // Reset held across the edge that ends ACCESS: no write.
      run_txn("pre24", 1'b1, 2'b00, 32'h24, 32'h0BAD_C0DE, 3, 1'b0, 32'hCAFE_F00D);
      @(negedge clk);
      req = 1'b1; wr = 1'b1; size = 2'b00; addr = 32'h24; wdata = 32'h7777_7777;
      @(posedge clk); #1;
      req = 1'b0;
      @(posedge clk); #1;
      check("racc.busy_before", 32'(busy), 32'd1);
      reset = 1'b1;
      @(posedge clk); #1;
      check("racc.busy", 32'(busy), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      run_txn("racc.load", 1'b0, 2'b00, 32'h24, 32'h0, 3, 1'b0, 32'h0BAD_C0DE);

      // Zero wait states, req held for three loads: acks at +2, +5, +8.
      @(negedge clk);
      req0 = 1'b1; wr0 = 1'b0; size0 = 2'b00; addr0 = 32'h0;
      @(posedge clk);
      for (int k = 1; k <= 10; k++) begin
         @(posedge clk); #1;
         if (k == 6) req0 = 1'b0;
         check($sformatf("held.ack%0d", k), 32'(ack0),
               32'((k == 2) || (k == 5) || (k == 8)));
         check($sformatf("held.busy%0d", k), 32'(busy0),
               32'((k == 1) || (k == 3) || (k == 4) || (k == 6) || (k == 7)));
      end

      // A req pulse while busy must not start a second transaction.
      @(negedge clk);
      req0 = 1'b1;
      @(posedge clk); #1;
      req0 = 1'b0;
      @(negedge clk);
      req0 = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         @(posedge clk); #1;
         if (k == 1) req0 = 1'b0;
         check($sformatf("pulse.ack%0d", k),  32'(ack0),  32'(k == 2));
         check($sformatf("pulse.busy%0d", k), 32'(busy0), 32'(k == 1));
         check($sformatf("pulse.err%0d", k),  32'(err0),  32'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
      $finish;
   end

endmodule
